// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-side SRAM responder.
// Holds the size encodings, reset-sync depth and the queue entry layout.
// Contents: SIZE_B/H/W, RST_SYNC_STAGES, TIMER_W, CNT_W, entry_t.
package data_sram_responder_pkg;

  // data_sram_size encodings. Informational only; byte lanes come from wstrb.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Flops in the reset-deassertion synchroniser.
  localparam int RST_SYNC_STAGES = 2;

  // RESP_LAT is at most 8, so the countdown never exceeds 7.
  localparam int TIMER_W = 3;
  // MAX_OUTST is at most 4.
  localparam int CNT_W   = 3;

  typedef struct packed {
    logic               is_read;
    logic [31:0]        rdata;
    logic [TIMER_W-1:0] timer;
  } entry_t;

endpackage

// File: rtl/data_sram_responder_if.sv
// Data-side SRAM request/response bundle between the execute stage and its target.
// Master drives req/wr/size/wstrb/addr/wdata; slave returns addr_ok, data_ok, rdata.
// The master holds request fields until addr_ok is seen with req high.
interface data_sram_responder_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder_resp_queue.sv
// In-order response FIFO with a per-entry countdown timer.
// Latency: an entry pushed at cycle T pops in cycle T+LAT (timer loaded with LAT-1).
// Backpressure: none on pop; the caller must not push when full unless pop is high.
// Ports: clk, rst_n (async active-low), push/push_is_read/push_rdata in,
//        pop/head_is_read/head_rdata/cnt out.
module data_sram_responder_resp_queue
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             push_is_read,
  input  logic [31:0]      push_rdata,
  output logic             pop,
  output logic             head_is_read,
  output logic [31:0]      head_rdata,
  output logic [CNT_W-1:0] cnt
);

  localparam int                 PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(LAT - 1);

  entry_t           ent [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign pop          = vld[head] & (ent[head].timer == '0);
  assign head_is_read = ent[head].is_read;
  assign head_rdata   = ent[head].rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= '0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld[i] && (ent[i].timer != '0)) ent[i].timer <= ent[i].timer - 1'b1;
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= ptr_inc(head);
      end
      // Placed after pop: on a full queue tail == head, and the new entry must win.
      if (push) begin
        vld[tail] <= 1'b1;
        ent[tail] <= '{is_read: push_is_read, rdata: push_rdata, timer: TIMER_INIT};
        tail      <= ptr_inc(tail);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// SRAM-like slave terminating the data-side request bus, backed by local word memory.
// Latency: accept at T -> data_ok at T+RESP_LAT; at most MAX_OUTST outstanding.
// Backpressure: addr_ok drops when the queue is full (and no head retires) or stall_i is high.
// Ports: clk, resetn (async active-low), stall_i, bus (slave side of data_sram_responder_if).
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int RESP_LAT    = 2,
  parameter int MAX_OUTST   = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 stall_i,
  data_sram_responder_if.slave bus
);

  localparam int               IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

  // Assert asynchronously, release after RST_SYNC_STAGES rising edges.
  logic [RST_SYNC_STAGES-1:0] rst_sync;
  logic                       core_rstn;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync <= '0;
    else         rst_sync <= {rst_sync[RST_SYNC_STAGES-2:0], 1'b1};
  end
  assign core_rstn = rst_sync[RST_SYNC_STAGES-1];

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             addr_ok_c;
  logic             pop;
  logic             head_is_read;
  logic [31:0]      head_rdata;
  logic [CNT_W-1:0] cnt;

  // Upper address bits wrap; the byte offset and size do not affect indexing.
  logic unused_bits;
  assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[1:0],
                         bus.data_sram_addr[31:IDX_W+2]};

  assign idx       = bus.data_sram_addr[IDX_W+1:2];
  // A retiring head frees its slot in the same cycle, so a full queue can still accept.
  assign addr_ok_c = core_rstn & ~stall_i & ((cnt < MAX_C) | pop);
  assign accept    = bus.data_sram_req & addr_ok_c;

  // Memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && bus.data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_sram_wstrb[b]) mem[idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
      end
    end
  end

  // Read word is captured into the queue entry at the accept edge.
  data_sram_responder_resp_queue #(
    .DEPTH (MAX_OUTST),
    .LAT   (RESP_LAT)
  ) u_resp_queue (
    .clk          (clk),
    .rst_n        (core_rstn),
    .push         (accept),
    .push_is_read (~bus.data_sram_wr),
    .push_rdata   (mem[idx]),
    .pop          (pop),
    .head_is_read (head_is_read),
    .head_rdata   (head_rdata),
    .cnt          (cnt)
  );

  assign bus.data_sram_addr_ok = addr_ok_c;
  assign bus.data_sram_data_ok = pop & core_rstn;
  assign bus.data_sram_rdata   = (pop & core_rstn & head_is_read) ? head_rdata : '0;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: two instances (default, and
// DEPTH_WORDS=16/RESP_LAT=3/MAX_OUTST=1) checked every cycle against a
// due-time queue model plus directed scenario checks.
module tb_data_sram_responder;
  import data_sram_responder_pkg::*;

  localparam int N = 2;

  function automatic int lat_of(input int k);   return (k == 0) ? 2 : 3;     endfunction
  function automatic int mx_of(input int k);    return (k == 0) ? 2 : 1;     endfunction
  function automatic int depth_of(input int k); return (k == 0) ? 1024 : 16; endfunction

  logic clk = 1'b0;
  logic resetn = 1'b0;
  initial forever #5 clk = ~clk;

  logic        req_v   [N];
  logic        wr_v    [N];
  logic        stall_v [N];
  logic [3:0]  strb_v  [N];
  logic [31:0] addr_v  [N];
  logic [31:0] wdat_v  [N];
  logic        aok_w   [N];
  logic        dok_w   [N];
  logic [31:0] rd_w    [N];

  data_sram_responder_if if0 ();
  data_sram_responder_if if1 ();

  assign if0.data_sram_req   = req_v[0];
  assign if0.data_sram_wr    = wr_v[0];
  assign if0.data_sram_size  = SIZE_W;
  assign if0.data_sram_wstrb = strb_v[0];
  assign if0.data_sram_addr  = addr_v[0];
  assign if0.data_sram_wdata = wdat_v[0];
  assign aok_w[0]            = if0.data_sram_addr_ok;
  assign dok_w[0]            = if0.data_sram_data_ok;
  assign rd_w[0]             = if0.data_sram_rdata;

  assign if1.data_sram_req   = req_v[1];
  assign if1.data_sram_wr    = wr_v[1];
  assign if1.data_sram_size  = SIZE_W;
  assign if1.data_sram_wstrb = strb_v[1];
  assign if1.data_sram_addr  = addr_v[1];
  assign if1.data_sram_wdata = wdat_v[1];
  assign aok_w[1]            = if1.data_sram_addr_ok;
  assign dok_w[1]            = if1.data_sram_data_ok;
  assign rd_w[1]             = if1.data_sram_rdata;

  data_sram_responder #(.DEPTH_WORDS(1024), .RESP_LAT(2), .MAX_OUTST(2)) dut0 (
    .clk(clk), .resetn(resetn), .stall_i(stall_v[0]), .bus(if0));
  data_sram_responder #(.DEPTH_WORDS(16), .RESP_LAT(3), .MAX_OUTST(1)) dut1 (
    .clk(clk), .resetn(resetn), .stall_i(stall_v[1]), .bus(if1));

  // Reference model: memory image plus a queue of (due cycle, response data).
  logic [31:0] mem_m [N][1024];
  int          q_due [N][8];
  logic [31:0] q_dat [N][8];
  int          q_hd  [N];
  int          q_n   [N];
  int          cyc;
  int          rel;      // rising edges seen with resetn high
  logic        exp_pop [N];
  logic        exp_aok [N];
  logic        acc     [N];
  int          acc_cyc [N];
  logic        obs_aok [N];
  logic        obs_dok [N];
  logic [31:0] obs_rd  [N];
  int          obs_cyc;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: predict, compare at negedge, advance model at posedge.
  task automatic step();
    for (int k = 0; k < N; k++) begin
      exp_pop[k] = (q_n[k] > 0) && (q_due[k][q_hd[k]] == cyc);
      exp_aok[k] = resetn && (rel >= 2) && !stall_v[k] && ((q_n[k] < mx_of(k)) || exp_pop[k]);
    end
    @(negedge clk);
    obs_cyc = cyc;
    for (int k = 0; k < N; k++) begin
      string sfx;
      sfx = (k == 0) ? "0" : "1";
      obs_aok[k] = aok_w[k];
      obs_dok[k] = dok_w[k];
      obs_rd[k]  = rd_w[k];
      chk({"addr_ok", sfx}, 32'(aok_w[k]), 32'(exp_aok[k]));
      chk({"data_ok", sfx}, 32'(dok_w[k]), 32'(exp_pop[k]));
      chk({"rdata", sfx}, rd_w[k], exp_pop[k] ? q_dat[k][q_hd[k]] : 32'h0);
    end
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      acc[k] = req_v[k] && exp_aok[k];
      if (exp_pop[k]) begin
        q_hd[k] = (q_hd[k] + 1) % 8;
        q_n[k]  = q_n[k] - 1;
      end
      if (acc[k]) begin
        int idx, t;
        idx = int'(addr_v[k] >> 2) % depth_of(k);
        t   = (q_hd[k] + q_n[k]) % 8;
        q_due[k][t] = cyc + lat_of(k);
        q_dat[k][t] = wr_v[k] ? 32'h0 : mem_m[k][idx];
        q_n[k]      = q_n[k] + 1;
        if (wr_v[k]) begin
          for (int b = 0; b < 4; b++)
            if (strb_v[k][b]) mem_m[k][idx][8*b +: 8] = wdat_v[k][8*b +: 8];
        end
      end
    end
    if (resetn && rel < 2) rel++;
    cyc++;
    #1;
  endtask

  task automatic issue(input int k, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input string tag);
    req_v[k] = 1'b1; wr_v[k] = w; addr_v[k] = a; wdat_v[k] = d; strb_v[k] = s;
    acc_cyc[k] = -1;
    for (int i = 0; i < 20; i++) begin
      int c;
      c = cyc;
      step();
      if (acc[k]) begin
        acc_cyc[k] = c;
        break;
      end
    end
    req_v[k] = 1'b0;
    chk({tag, "_accepted"}, 32'(acc_cyc[k] >= 0), 32'd1);
  endtask

  task automatic wait_resp(input int k, input logic [31:0] exp_data, input string tag);
    int          got_cyc;
    logic [31:0] d;
    got_cyc = -1;
    d       = 32'h0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_dok[k]) begin
        got_cyc = obs_cyc;
        d       = obs_rd[k];
        break;
      end
    end
    chk({tag, "_data"}, d, exp_data);
    chk({tag, "_lat"}, 32'(got_cyc), 32'(acc_cyc[k] + lat_of(k)));
  endtask

  initial begin
    logic [2:0] rv;
    logic [5:0] bv;
    logic [8:0] mv;
    int         first;
    for (int k = 0; k < N; k++) begin
      req_v[k] = 1'b0; wr_v[k] = 1'b0; stall_v[k] = 1'b0; strb_v[k] = 4'h0;
      addr_v[k] = 32'h0; wdat_v[k] = 32'h0; q_hd[k] = 0; q_n[k] = 0;
      acc[k] = 1'b0; acc_cyc[k] = 0;
    end
    cyc = 0;
    rel = 0;
    @(posedge clk); #1;

    // Reset state, then addr_ok rising on the second edge after release.
    repeat (3) step();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      rv[i] = obs_aok[0];
    end
    chk("rst_release_aok", 32'(rv), 32'(3'b100));

    // Fill the low 16 words of both memories so later reads are defined.
    for (int w = 0; w < 16; w++)
      for (int k = 0; k < N; k++) issue(k, 1'b1, 32'(w * 4), $urandom(), 4'hF, "fill");
    repeat (4) step();

    // Word write then read.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_word");
    wait_resp(0, 32'h0, "wr_word");
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, "rd_word");
    wait_resp(0, 32'hDEADBEEF, "rd_word");

    // Single byte lane.
    issue(0, 1'b1, 32'h12, 32'h12121212, 4'b0100, "wr_byte");
    wait_resp(0, 32'h0, "wr_byte");
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, "rd_byte");
    wait_resp(0, 32'hDE12BEEF, "rd_byte");

    // Four back-to-back reads on a two-deep queue.
    for (int i = 0; i < 6; i++) begin
      req_v[0] = (i < 4); wr_v[0] = 1'b0; addr_v[0] = 32'(i * 4);
      step();
      bv[i] = obs_dok[0];
      if (i < 4) chk("b2b_accept", 32'(acc[0]), 32'd1);
    end
    req_v[0] = 1'b0;
    chk("b2b_data_ok_pattern", 32'(bv), 32'(6'b111100));
    repeat (3) step();

    // MAX_OUTST=1, RESP_LAT=3: accepts every third cycle.
    req_v[1] = 1'b1; wr_v[1] = 1'b0; addr_v[1] = 32'h20;
    for (int i = 0; i < 9; i++) begin
      step();
      mv[i] = acc[1];
    end
    req_v[1] = 1'b0;
    chk("m1_accept_pattern", 32'(mv), 32'(9'b001001001));
    repeat (4) step();

    // stall_i held for 5 cycles with a pending request.
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, "st_rd");
    stall_v[0] = 1'b1; req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 32'h14;
    first = -1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (obs_dok[0] && first < 0) first = obs_cyc;
    end
    chk("st_resp_lat", 32'(first), 32'(acc_cyc[0] + 2));
    stall_v[0] = 1'b0;
    step();
    chk("st_release_accept", 32'(acc[0]), 32'd1);
    req_v[0] = 1'b0;
    repeat (4) step();

    // Async reset with two reads in flight, first one due this cycle.
    req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 32'h10;
    step();
    step();
    req_v[0] = 1'b0;
    resetn = 1'b0;
    #1;
    chk("arst_data_ok", 32'(dok_w[0]), 32'd0);
    chk("arst_addr_ok", 32'(aok_w[0]), 32'd0);
    chk("arst_rdata", rd_w[0], 32'h0);
    for (int k = 0; k < N; k++) q_n[k] = 0;
    rel = 0;
    repeat (2) step();
    resetn = 1'b1;
    repeat (5) step();
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, "arst_mem");
    wait_resp(0, 32'hDE12BEEF, "arst_mem");

    // Randomised traffic on both instances; fields held until accepted.
    for (int k = 0; k < N; k++) acc[k] = 1'b0;
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_v[k] || acc[k]) begin
          logic [31:0] r;
          logic [3:0]  w;
          r = $urandom();
          w = 4'($urandom_range(0, 15));
          req_v[k]  = ($urandom_range(0, 2) != 0);
          wr_v[k]   = ($urandom_range(0, 1) != 0);
          strb_v[k] = 4'($urandom_range(0, 15));
          wdat_v[k] = $urandom();
          addr_v[k] = {r[19:0], 6'b0, w, r[21:20]};
        end
        stall_v[k] = ($urandom_range(0, 5) == 0);
      end
      step();
    end
    for (int k = 0; k < N; k++) begin
      req_v[k] = 1'b0;
      stall_v[k] = 1'b0;
    end
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
